// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared defaults and helpers for the in-order pipeline hazard controller.
package hazard_ctrl_unit_pkg;

    localparam int DBITS_DEF        = 32;
    localparam int REG_BITS_DEF     = 4;
    localparam int PIPE_DEPTH_DEF   = 3;
    localparam int FLUSH_CYCLES_DEF = 2;
    localparam int CNT_BITS_DEF     = 16;

    // With forwarding only a load still in the first slot cannot be bypassed.
    function automatic logic entry_can_hazard(input logic valid, input logic is_load,
                                              input logic is_head, input logic fwd_en);
        if (fwd_en)
            return valid & is_load & is_head;
        return valid;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight destination registers with parallel rs1/rs2 compare.
module hazard_scoreboard
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_BITS   = REG_BITS_DEF,
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
    parameter int FWD_EN     = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                push_valid,
    input  logic [REG_BITS-1:0] push_rd,
    input  logic                push_is_load,
    input  logic                dec_valid,
    input  logic [REG_BITS-1:0] dec_rs1,
    input  logic [REG_BITS-1:0] dec_rs2,
    output logic                hit
);

    logic [PIPE_DEPTH-1:0] ent_valid;
    logic [PIPE_DEPTH-1:0] ent_load;
    logic [REG_BITS-1:0]   ent_rd [PIPE_DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_valid <= '0;
        end else begin
            ent_valid[0] <= push_valid;
            for (int i = 1; i < PIPE_DEPTH; i++)
                ent_valid[i] <= ent_valid[i-1];
        end
    end

    // Payload is only meaningful under ent_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        ent_rd[0]   <= push_rd;
        ent_load[0] <= push_is_load;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            ent_rd[i]   <= ent_rd[i-1];
            ent_load[i] <= ent_load[i-1];
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (entry_can_hazard(ent_valid[i], ent_load[i], i == 0, FWD_EN != 0)) begin
                if ((dec_rs1 != '0) && (dec_rs1 == ent_rd[i]))
                    hit = 1'b1;
                if ((dec_rs2 != '0) && (dec_rs2 == ent_rd[i]))
                    hit = 1'b1;
            end
        end
        hit = hit & dec_valid;
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: RAW stalls from the scoreboard, multi-cycle flush on EX redirects,
// saturating stall-cycle counter.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int DBITS        = DBITS_DEF,
    parameter int REG_BITS     = REG_BITS_DEF,
    parameter int PIPE_DEPTH   = PIPE_DEPTH_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int FWD_EN       = 0,
    parameter int CNT_BITS     = CNT_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                dec_valid,
    input  logic [REG_BITS-1:0] dec_rs1,
    input  logic [REG_BITS-1:0] dec_rs2,
    input  logic [REG_BITS-1:0] dec_rd,
    input  logic                dec_wr_en,
    input  logic                dec_is_load,
    input  logic                ex_redirect,
    input  logic [DBITS-1:0]    ex_target,
    output logic                if_stall,
    output logic                pc_redirect,
    output logic [DBITS-1:0]    redirect_pc,
    output logic                if_flush,
    output logic                dec_flush,
    output logic [CNT_BITS-1:0] stall_count
);

    localparam int              FC_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);

    logic             redirect_now;
    logic             raw_hit;
    logic             issue;
    logic             push_valid;
    logic             flushing;
    logic [FC_W-1:0]  flush_cnt;
    logic [DBITS-1:0] last_target;

    // Reset must silence the outputs at once, including the pass-through redirect.
    assign redirect_now = ex_redirect & reset_n;
    assign flushing     = redirect_now | (flush_cnt != '0);

    assign if_stall    = raw_hit & ~redirect_now;
    assign issue       = dec_valid & ~if_stall & ~redirect_now & (flush_cnt == '0);
    assign push_valid  = issue & dec_wr_en & (dec_rd != '0);

    assign pc_redirect = redirect_now;
    assign redirect_pc = redirect_now ? ex_target : last_target;
    assign if_flush    = flushing;
    assign dec_flush   = flushing;

    hazard_scoreboard #(
        .REG_BITS   (REG_BITS),
        .PIPE_DEPTH (PIPE_DEPTH),
        .FWD_EN     (FWD_EN)
    ) u_scoreboard (
        .clk          (clk),
        .reset_n      (reset_n),
        .push_valid   (push_valid),
        .push_rd      (dec_rd),
        .push_is_load (dec_is_load),
        .dec_valid    (dec_valid),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .hit          (raw_hit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_cnt   <= '0;
            last_target <= '0;
        end else if (redirect_now) begin
            flush_cnt   <= FC_LOAD;
            last_target <= ex_target;
        end else if (flush_cnt != '0) begin
            flush_cnt   <= flush_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_count <= '0;
        else if (if_stall && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: three instances (no forwarding, forwarding, 4-bit counter).
module tb_hazard_ctrl_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dec_valid;
    logic [3:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_wr_en, dec_is_load;
    logic        ex_redirect;
    logic [31:0] ex_target;

    logic        a_if_stall, a_pc_redirect, a_if_flush, a_dec_flush;
    logic [31:0] a_redirect_pc;
    logic [15:0] a_stall_count;
    logic        b_if_stall, b_pc_redirect, b_if_flush, b_dec_flush;
    logic [31:0] b_redirect_pc;
    logic [15:0] b_stall_count;
    logic        c_if_stall, c_pc_redirect, c_if_flush, c_dec_flush;
    logic [31:0] c_redirect_pc;
    logic [3:0]  c_stall_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.FWD_EN(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rd(dec_rd), .dec_wr_en(dec_wr_en), .dec_is_load(dec_is_load), .ex_redirect(ex_redirect),
        .ex_target(ex_target), .if_stall(a_if_stall), .pc_redirect(a_pc_redirect),
        .redirect_pc(a_redirect_pc), .if_flush(a_if_flush), .dec_flush(a_dec_flush),
        .stall_count(a_stall_count)
    );

    hazard_ctrl_unit #(.FWD_EN(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rd(dec_rd), .dec_wr_en(dec_wr_en), .dec_is_load(dec_is_load), .ex_redirect(ex_redirect),
        .ex_target(ex_target), .if_stall(b_if_stall), .pc_redirect(b_pc_redirect),
        .redirect_pc(b_redirect_pc), .if_flush(b_if_flush), .dec_flush(b_dec_flush),
        .stall_count(b_stall_count)
    );

    hazard_ctrl_unit #(.FWD_EN(0), .CNT_BITS(4)) dut_c (
        .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rd(dec_rd), .dec_wr_en(dec_wr_en), .dec_is_load(dec_is_load), .ex_redirect(ex_redirect),
        .ex_target(ex_target), .if_stall(c_if_stall), .pc_redirect(c_pc_redirect),
        .redirect_pc(c_redirect_pc), .if_flush(c_if_flush), .dec_flush(c_dec_flush),
        .stall_count(c_stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        dec_valid   = 1'b0;
        dec_rs1     = 4'd0;
        dec_rs2     = 4'd0;
        dec_rd      = 4'd0;
        dec_wr_en   = 1'b0;
        dec_is_load = 1'b0;
        ex_redirect = 1'b0;
        ex_target   = 32'h0;
    endtask

    task automatic issue(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                         input logic wr, input logic ld);
        dec_valid   = 1'b1;
        dec_rs1     = rs1;
        dec_rs2     = rs2;
        dec_rd      = rd;
        dec_wr_en   = wr;
        dec_is_load = ld;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset values
        idle();
        reset_n = 1'b0;
        tick();
        settle();
        chk("rst_if_stall", {31'b0, a_if_stall}, 32'd0);
        chk("rst_pc_redirect", {31'b0, a_pc_redirect}, 32'd0);
        chk("rst_redirect_pc", a_redirect_pc, 32'h0);
        chk("rst_if_flush", {31'b0, a_if_flush}, 32'd0);
        chk("rst_stall_count", {16'b0, a_stall_count}, 32'd0);
        tick();
        reset_n = 1'b1;
        settle();
        chk("rel_no_stall", {31'b0, a_if_stall}, 32'd0);

        // RAW without forwarding: producer rd=5, consumer rs1=5
        do_reset();
        issue(4'd0, 4'd0, 4'd5, 1'b1, 1'b0);
        settle();
        chk("raw_prod_no_stall", {31'b0, a_if_stall}, 32'd0);
        tick();
        issue(4'd5, 4'd0, 4'd0, 1'b0, 1'b0);
        settle();
        chk("raw_stall_c1", {31'b0, a_if_stall}, 32'd1);
        chk("raw_fwd_alu_no_stall", {31'b0, b_if_stall}, 32'd0);
        tick();
        chk("raw_stall_c2", {31'b0, a_if_stall}, 32'd1);
        tick();
        chk("raw_stall_c3", {31'b0, a_if_stall}, 32'd1);
        tick();
        chk("raw_stall_cleared", {31'b0, a_if_stall}, 32'd0);
        chk("raw_stall_count", {16'b0, a_stall_count}, 32'd3);
        chk("raw_fwd_stall_count", {16'b0, b_stall_count}, 32'd0);

        // Load-use with forwarding
        do_reset();
        issue(4'd0, 4'd0, 4'd7, 1'b1, 1'b1);
        tick();
        issue(4'd0, 4'd7, 4'd0, 1'b0, 1'b0);
        settle();
        chk("lu_stall", {31'b0, b_if_stall}, 32'd1);
        tick();
        chk("lu_stall_one_cycle", {31'b0, b_if_stall}, 32'd0);
        chk("lu_stall_count", {16'b0, b_stall_count}, 32'd1);
        issue(4'd0, 4'd0, 4'd7, 1'b1, 1'b0);
        tick();
        issue(4'd0, 4'd7, 4'd0, 1'b0, 1'b0);
        settle();
        chk("alu_use_no_stall", {31'b0, b_if_stall}, 32'd0);
        do_reset();
        issue(4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
        tick();
        issue(4'd0, 4'd0, 4'd3, 1'b1, 1'b0);
        settle();
        chk("rd0_no_stall_nofwd", {31'b0, a_if_stall}, 32'd0);
        chk("rd0_no_stall_fwd", {31'b0, b_if_stall}, 32'd0);

        // Redirect and flush window
        do_reset();
        ex_redirect = 1'b1;
        ex_target   = 32'h0000_0100;
        settle();
        chk("redir_pc_redirect", {31'b0, a_pc_redirect}, 32'd1);
        chk("redir_target", a_redirect_pc, 32'h0000_0100);
        chk("redir_if_flush_w0", {31'b0, a_if_flush}, 32'd1);
        chk("redir_dec_flush_w0", {31'b0, a_dec_flush}, 32'd1);
        tick();
        ex_redirect = 1'b0;
        ex_target   = 32'hDEAD_BEEF;
        settle();
        chk("redir_pulse_end", {31'b0, a_pc_redirect}, 32'd0);
        chk("redir_pc_hold", a_redirect_pc, 32'h0000_0100);
        chk("redir_flush_w1", {31'b0, a_if_flush}, 32'd1);
        tick();
        chk("redir_flush_w2", {31'b0, a_dec_flush}, 32'd1);
        tick();
        chk("redir_flush_end", {31'b0, a_if_flush}, 32'd0);

        // Redirect coinciding with RAW hit, then a second redirect extending the window
        do_reset();
        issue(4'd0, 4'd0, 4'd5, 1'b1, 1'b0);
        tick();
        issue(4'd5, 4'd0, 4'd6, 1'b1, 1'b0);
        ex_redirect = 1'b1;
        ex_target   = 32'h0000_0200;
        settle();
        chk("rr_no_stall", {31'b0, a_if_stall}, 32'd0);
        chk("rr_pc_redirect", {31'b0, a_pc_redirect}, 32'd1);
        chk("rr_target1", a_redirect_pc, 32'h0000_0200);
        tick();
        idle();
        ex_redirect = 1'b1;
        ex_target   = 32'h0000_0300;
        settle();
        chk("rr_target2", a_redirect_pc, 32'h0000_0300);
        chk("rr_flush_r2", {31'b0, a_if_flush}, 32'd1);
        tick();
        ex_redirect = 1'b0;
        settle();
        chk("rr_flush_r3", {31'b0, a_if_flush}, 32'd1);
        tick();
        issue(4'd6, 4'd0, 4'd0, 1'b0, 1'b0);
        settle();
        chk("rr_flush_extended", {31'b0, a_if_flush}, 32'd1);
        chk("rr_squashed_not_pushed", {31'b0, a_if_stall}, 32'd0);
        tick();
        chk("rr_flush_end", {31'b0, a_if_flush}, 32'd0);

        // Back-to-back self-dependent instructions: 3 stalls per 4 cycles
        do_reset();
        issue(4'd5, 4'd0, 4'd5, 1'b1, 1'b0);
        repeat (16) tick();
        chk("sat_pre_count", {28'b0, c_stall_count}, 32'd12);
        repeat (24) tick();
        chk("sat_count_16b", {16'b0, a_stall_count}, 32'd30);
        chk("sat_count_4b", {28'b0, c_stall_count}, 32'd15);
        chk("sat_fwd_count", {16'b0, b_stall_count}, 32'd0);

        // Reset asserted while stalled and flushing
        do_reset();
        issue(4'd0, 4'd0, 4'd5, 1'b1, 1'b0);
        tick();
        idle();
        ex_redirect = 1'b1;
        ex_target   = 32'h0000_0400;
        tick();
        ex_redirect = 1'b0;
        issue(4'd5, 4'd0, 4'd0, 1'b0, 1'b0);
        settle();
        chk("mid_pre_stall", {31'b0, a_if_stall}, 32'd1);
        chk("mid_pre_flush", {31'b0, a_if_flush}, 32'd1);
        tick();
        chk("mid_pre_count", {16'b0, a_stall_count}, 32'd1);
        #2;
        reset_n     = 1'b0;
        ex_redirect = 1'b1;
        ex_target   = 32'h0000_0500;
        settle();
        chk("mid_rst_if_stall", {31'b0, a_if_stall}, 32'd0);
        chk("mid_rst_pc_redirect", {31'b0, a_pc_redirect}, 32'd0);
        chk("mid_rst_redirect_pc", a_redirect_pc, 32'h0);
        chk("mid_rst_if_flush", {31'b0, a_if_flush}, 32'd0);
        chk("mid_rst_dec_flush", {31'b0, a_dec_flush}, 32'd0);
        chk("mid_rst_count", {16'b0, a_stall_count}, 32'd0);
        ex_redirect = 1'b0;
        tick();
        reset_n = 1'b1;
        settle();
        chk("mid_rel_no_stale", {31'b0, a_if_stall}, 32'd0);
        chk("mid_rel_no_flush", {31'b0, a_if_flush}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
